// File: rtl/byte_serial_adder_pkg.sv
// Shared constants and FSM encoding for the byte-serial adder.
package byte_serial_adder_pkg;

  localparam int unsigned BYTE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_serial_adder_cla8_slice.sv
// Combinational 8-bit carry-lookahead adder slice.
module cla8_slice
  import byte_serial_adder_pkg::*;
(
  input  logic [BYTE-1:0] a_i,
  input  logic [BYTE-1:0] b_i,
  input  logic            cin_i,
  output logic [BYTE-1:0] sum_o,
  output logic            cout_o
);

  logic [BYTE-1:0] g;
  logic [BYTE-1:0] p;
  logic [BYTE:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each carry is a flat sum of generate terms masked by the propagate chain below it.
  always_comb begin
    logic pp;
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < int'(BYTE); i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin_i);
    end
  end

  assign sum_o  = p ^ c[BYTE-1:0];
  assign cout_o = c[BYTE];

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte add/subtract engine: one CLA slice per cycle, LSB byte first.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BYTE*NBYTES-1:0] in_a,
  input  logic [BYTE*NBYTES-1:0] in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BYTE*NBYTES-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int unsigned W    = BYTE * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q;
  logic            ovf_q;
  logic            out_valid_q;
  logic            in_ready_q;

  logic [BYTE-1:0] slice_sum;
  logic            slice_cout;
  logic            last_byte;

  cla8_slice u_slice (
    .a_i    (a_q[BYTE-1:0]),
    .b_i    (b_q[BYTE-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  assign last_byte = (idx_q == IDXW'(NBYTES - 1));

  // FSM, operand shift registers, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b ^ {W{in_sub}};
            carry_q    <= in_sub | in_cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Operands shift down so the slice always sees the current byte at the bottom.
          sum_q   <= {slice_sum, sum_q[W-1:BYTE]};
          a_q     <= a_q >> BYTE;
          b_q     <= b_q >> BYTE;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IDXW'(1);
          if (last_byte) begin
            cout_q  <= slice_cout;
            ovf_q   <= (a_q[BYTE-1] == b_q[BYTE-1]) && (slice_sum[BYTE-1] != a_q[BYTE-1]);
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder with directed vectors.
module tb_byte_serial_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           hs;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: checks latency on out_valid rise and pops the scoreboard on each result handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid && sb.size() > 0 && sb[0].lat)
        chk("latency", W'(cyc - sb[0].hs), W'(NB + 1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", out_sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum",  out_sum,       e.sum);
          chk("cout", W'(out_cout),  W'(e.cout));
          chk("ovf",  W'(out_ovf),   W'(e.ovf));
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                    input logic sub, input logic [W-1:0] esum, input logic ecout,
                    input logic eovf, input bit lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 after %0d cycles", n);
      return;
    end
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    if (push) sb.push_back('{esum, ecout, eovf, cyc + 1, lat});
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~cin;
    in_sub   = ~sub;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_sum",   out_sum,       W'(0));
    chk("rst_out_cout",  W'(out_cout),  W'(0));
    chk("rst_out_ovf",   W'(out_ovf),   W'(0));

    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    op(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-pressure: hold the result in DONE, poke in_valid, then release.
    @(posedge clk);
    #1 out_ready = 1'b0;
    op(32'h0001_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0002_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1111_1111;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_in_ready",  W'(in_ready),  W'(0));
      chk("bp_out_sum",   out_sum,       32'h0002_0000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset during RUN discards the operation.
    op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready",  W'(in_ready),  W'(1));
    chk("midrst_out_sum",   out_sum,       W'(0));
    rst = 1'b0;

    op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
